codificador_pt2262: RTL and testbench
=====================================

Name: codificador_pt2262

Overview:
- Serial remote-control encoder that produces the PT2262-format code stream consumed on `cod_i` of the PT2272-style decoder.
- Takes an 8-position ternary address (0/1/FLOAT) and a 4-bit data word, and transmits frames of 12 code bits followed by a sync bit.
- Runs from the 3 MHz system clock and generates its own 12 kHz symbol tick internally as a clock enable, not a derived clock.
- On a remote it sits upstream of the RF link; in the test system its output connects directly to the decoder's `cod_i`.

Parameters:
- DIV, 250: system clocks per symbol tick (alpha). 3 MHz / 250 = 12 kHz.
- MIN_FRAMES, 4: minimum number of complete frames sent per `send` assertion.

Ports:
- clk  input  1  system clock, 3 MHz.
- reset  input  1  synchronous, active-high reset.
- addr_val  input  8  address bit value, used when the matching addr_float bit is 0.
- addr_float  input  8  1 = address position is FLOAT; takes priority over addr_val.
- D  input  4  data word; always binary, never FLOAT.
- send  input  1  transmit request, level-sensitive (PT2262 TE equivalent).
- cod_o  output  1  encoded serial stream, registered.
- busy  output  1  high while a frame is in progress.
- frame_done  output  1  one-clk pulse at the end of each frame's sync bit.

Behaviour:
- Reset values: cod_o=0, busy=0, frame_done=0, FSM in IDLE, divider=0, frame counter=0.
- Reset is synchronous and active-high. Asserting it mid-frame aborts the frame: all outputs take reset values on the next edge. A new frame then requires `send` again.
- Tick generation: a divider counts 0..DIV-1, and `tick` is high for one clk when it reaches DIV-1. It free-runs after reset. All FSM and position updates occur only on edges where tick=1.
- FSM states: IDLE, BIT, SYNC.
  - BIT uses a 5-bit position counter pos (0..31) and a 4-bit bit index (0..11).
  - SYNC uses a 7-bit position counter (0..127).
- Symbol waveform in BIT, by pos:
  - pos 0-3: cod_o=1.
  - pos 4-11: cod_o=1 only for symbol '1'.
  - pos 12-15: cod_o=0.
  - pos 16-19: cod_o=1.
  - pos 20-27: cod_o=1 for symbols '1' and 'F'.
  - pos 28-31: cod_o=0.
  - Resulting shapes: '0' = 4H12L4H12L; '1' = 12H4L12H4L; 'F' = 4H12L12H4L.
- Sync waveform: cod_o=1 for pos 0-3, cod_o=0 for pos 4-127.
- Bit order: bit indices 0..7 carry A0..A7, then indices 8..11 carry D[3], D[2], D[1], D[0].
- Frame length: 12×32 + 128 = 512 ticks.
- IDLE → BIT: on a tick with send=1.
  - Latch addr_val, addr_float and D into shadow registers.
  - On the same edge: pos=0, bit index=0, cod_o←1, busy←1, frame counter cleared.
- BIT transitions:
  - pos wraps from 31 to 0 and the bit index increments.
  - After bit index 11, pos 31, go to SYNC at pos 0.
- End of SYNC (tick at pos 127):
  - frame_done=1 for exactly that clk, and the frame counter increments, saturating at MIN_FRAMES.
  - If send=1 or the counter (after increment) < MIN_FRAMES: start a new frame on the same edge, relatching inputs, with cod_o←1.
  - Otherwise: go to IDLE with cod_o←0 and busy←0.
- Input changes mid-frame have no effect; the shadow registers are updated only at frame start.
- Deasserting send mid-frame has no effect; the current frame always completes.
- busy equals (state != IDLE) and is registered.

Optional Feature:
- Macro: CODIFICADOR_FAST_TICK_EN.
- Defined: the divider is removed and tick is constant 1, so one symbol position equals one clk. This is for fast simulation and co-simulation with the decoder run on the same fast clock.
- Undefined: the normal DIV-cycle tick as specified above.
- FSM and waveform rules are identical in both cases.

Test Plan:
- Reset held, then send=0 for 2000 clks -> cod_o=0, busy=0, frame_done never pulses.
- FAST_TICK, addr_val=8'h01, addr_float=0, D=4'hA, send high for 1 clk:
  - exactly 4 frames are sent, with 4 frame_done pulses 512 clks apart;
  - bit0 waveform is 12H4L12H4L, bit1 is 4H12L4H12L;
  - data bits are 1,0,1,0;
  - busy falls 2048 clks after start.
- FAST_TICK, addr_float=8'h80 -> bit 7 of every frame is 4H12L12H4L, regardless of addr_val[7].
- FAST_TICK, send held for 6×512 clks -> exactly 6 or 7 frames depending on send release alignment, then IDLE.
  - Also: D changed from 4'hA to 4'h5 at tick 100 of frame 1 -> frame 1 carries A, frame 2 carries 5.
- FAST_TICK, reset asserted at tick 200 of frame 2 -> next edge cod_o=0, busy=0; no further activity until send.
- No macro, D=4'h0, address all 0 -> first high pulse of cod_o lasts 4×250=1000 clks; frame_done spacing is 128000 clks.

Source files
------------

// File: rtl/codificador_pt2262.sv
// codificador_pt2262: PT2262-style ternary remote-control encoder.
// Each frame is 12 code bits (A0..A7, then D3..D0) and a sync bit, 512 symbol
// positions in all. A send request produces at least MIN_FRAMES frames.
// The symbol tick is a clock enable made from a DIV-cycle divider. Defining
// CODIFICADOR_FAST_TICK_EN removes the divider, so there is one position per clk.
module codificador_pt2262 #(
  parameter int DIV        = 250,
  parameter int MIN_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr_val,
  input  logic [7:0] addr_float,
  input  logic [3:0] D,
  input  logic       send,
  output logic       cod_o,
  output logic       busy,
  output logic       frame_done
);

  localparam int FCW = $clog2(MIN_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, BIT, SYNC} state_t;

  state_t         state_q, state_d;
  logic [6:0]     pos_q, pos_d;
  logic [3:0]     bitIdx_q, bitIdx_d;
  logic [FCW-1:0] frameCnt_q, frameCnt_d;
  logic [FCW-1:0] cntInc;
  logic [7:0]     addrVal_q, addrVal_d;
  logic [7:0]     addrFloat_q, addrFloat_d;
  logic [3:0]     data_q, data_d;
  logic           cod_q, cod_d;
  logic           busy_q, busy_d;
  logic           frameDone_q, frameDone_d;
  logic           tick;
  logic           startNew;
  logic           curOne, curFloat;
  logic [1:0]     dataSel;
  logic [4:0]     bitPos;
  logic           bitLevel;

`ifdef CODIFICADOR_FAST_TICK_EN
  assign tick = 1'b1;
`else
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DCW-1:0] divCnt_q;

  assign tick = (divCnt_q == DCW'(DIV - 1));

  // Free-running symbol divider; wraps to 0 on the tick cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt_q <= '0;
    end else if (tick) begin
      divCnt_q <= '0;
    end else begin
      divCnt_q <= divCnt_q + DCW'(1);
    end
  end
`endif

  // Ternary symbol carried by the current bit index, taken from the shadow copies.
  always_comb begin
    dataSel  = ~bitIdx_q[1:0];
    curFloat = 1'b0;
    curOne   = 1'b0;
    if (!bitIdx_q[3]) begin
      curFloat = addrFloat_q[bitIdx_q[2:0]];
      curOne   = !addrFloat_q[bitIdx_q[2:0]] && addrVal_q[bitIdx_q[2:0]];
    end else begin
      curOne   = data_q[dataSel];
    end
  end

  // Next-state logic. Positions advance only on tick; cod/busy are derived from the next position.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    bitIdx_d    = bitIdx_q;
    frameCnt_d  = frameCnt_q;
    addrVal_d   = addrVal_q;
    addrFloat_d = addrFloat_q;
    data_d      = data_q;
    frameDone_d = 1'b0;
    startNew    = 1'b0;
    cntInc      = (frameCnt_q >= FCW'(MIN_FRAMES)) ? FCW'(MIN_FRAMES)
                                                   : frameCnt_q + FCW'(1);
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (send) begin
            startNew   = 1'b1;
            frameCnt_d = '0;
          end
        end
        BIT: begin
          if (pos_q[4:0] == 5'd31) begin
            pos_d = '0;
            if (bitIdx_q == 4'd11) begin
              state_d = SYNC;
            end else begin
              bitIdx_d = bitIdx_q + 4'd1;
            end
          end else begin
            pos_d = pos_q + 7'd1;
          end
        end
        SYNC: begin
          if (pos_q == 7'd127) begin
            frameDone_d = 1'b1;
            frameCnt_d  = cntInc;
            if (send || (cntInc < FCW'(MIN_FRAMES))) begin
              startNew = 1'b1;
            end else begin
              state_d = IDLE;
              pos_d   = '0;
            end
          end else begin
            pos_d = pos_q + 7'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (startNew) begin
      state_d     = BIT;
      pos_d       = '0;
      bitIdx_d    = '0;
      addrVal_d   = addr_val;
      addrFloat_d = addr_float;
      data_d      = D;
    end

    // Position 0 is always high, so a freshly entered bit never needs its own symbol here.
    bitPos = pos_d[4:0];
    if (bitPos < 5'd4)       bitLevel = 1'b1;
    else if (bitPos < 5'd12) bitLevel = curOne;
    else if (bitPos < 5'd16) bitLevel = 1'b0;
    else if (bitPos < 5'd20) bitLevel = 1'b1;
    else if (bitPos < 5'd28) bitLevel = curOne | curFloat;
    else                     bitLevel = 1'b0;

    case (state_d)
      BIT:     cod_d = bitLevel;
      SYNC:    cod_d = (pos_d < 7'd4);
      default: cod_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Encoder FSM, shadow registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      bitIdx_q    <= '0;
      frameCnt_q  <= '0;
      addrVal_q   <= '0;
      addrFloat_q <= '0;
      data_q      <= '0;
      cod_q       <= 1'b0;
      busy_q      <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      bitIdx_q    <= bitIdx_d;
      frameCnt_q  <= frameCnt_d;
      addrVal_q   <= addrVal_d;
      addrFloat_q <= addrFloat_d;
      data_q      <= data_d;
      cod_q       <= cod_d;
      busy_q      <= busy_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign cod_o      = cod_q;
  assign busy       = busy_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_codificador_pt2262.sv
// Testbench for codificador_pt2262. A fast instance (small divider) is checked
// every cycle against a frame-level model; a second instance with the default
// divider checks the real symbol timing of the first pulse.
module tb_codificador_pt2262;

  localparam int DIV_TB = 2;
  localparam int MINF   = 4;
  localparam int FRAME  = 512;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addrVal;
  logic [7:0] addrFloat;
  logic [3:0] dataIn;
  logic       send;
  logic       sendSlow;
  logic       codFast, busyFast, doneFast;
  logic       codSlow, busySlow, doneSlow;

  int checkCount = 0;
  int errorCount = 0;

  codificador_pt2262 #(.DIV(DIV_TB), .MIN_FRAMES(MINF)) dut (
    .clk(clk), .reset(reset), .addr_val(addrVal), .addr_float(addrFloat),
    .D(dataIn), .send(send), .cod_o(codFast), .busy(busyFast), .frame_done(doneFast)
  );

  codificador_pt2262 dutSlow (
    .clk(clk), .reset(reset), .addr_val(addrVal), .addr_float(addrFloat),
    .D(dataIn), .send(sendSlow), .cod_o(codSlow), .busy(busySlow), .frame_done(doneSlow)
  );

  always #5 clk = ~clk;

  // Frame-level model: a frame is 512 ticks; offset t selects bit t/32, position t%32.
  bit         modelValid = 1'b0;
  int         mTickCnt, mT, mFrames;
  bit         mActive, mDone, tickNow;
  logic [7:0] mVal, mFlt;
  logic [3:0] mD;
  logic       expCod, expBusy, expDone;

  function automatic logic frameLevel(input int t);
    int b, p, sym;
    if (t >= 384) return (t - 384) < 4;
    b = t / 32;
    p = t % 32;
    if (b < 8) sym = mFlt[b] ? 2 : int'(mVal[b]);
    else       sym = int'(mD[11 - b]);
    case (sym)
      0:       return (p < 4) || (p >= 16 && p < 20);
      1:       return (p < 12) || (p >= 16 && p < 28);
      default: return (p < 4) || (p >= 16 && p < 28);
    endcase
  endfunction

  // Advance the model on every rising edge, using the inputs seen at that edge.
  always @(posedge clk) begin
    if (reset) begin
      mTickCnt = 0; mActive = 0; mT = 0; mFrames = 0; mDone = 0;
      modelValid = 1'b1;
    end else begin
      mDone = 0;
      if (mTickCnt == DIV_TB - 1) begin mTickCnt = 0; tickNow = 1; end
      else begin mTickCnt++; tickNow = 0; end
      if (tickNow) begin
        if (!mActive) begin
          if (send) begin
            mActive = 1; mT = 0; mFrames = 0;
            mVal = addrVal; mFlt = addrFloat; mD = dataIn;
          end
        end else if (mT == FRAME - 1) begin
          mDone = 1;
          if (mFrames < MINF) mFrames++;
          if (send || mFrames < MINF) begin
            mT = 0; mVal = addrVal; mFlt = addrFloat; mD = dataIn;
          end else begin
            mActive = 0;
          end
        end else begin
          mT++;
        end
      end
    end
    expCod  = mActive ? frameLevel(mT) : 1'b0;
    expBusy = mActive;
    expDone = mDone;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of the fast instance against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cod_o", int'(codFast), int'(expCod));
      checkOutput("busy", int'(busyFast), int'(expBusy));
      checkOutput("frame_done", int'(doneFast), int'(expDone));
    end
  end

  // Event monitor: cycle count, frame_done pulses and busy edges of the fast instance.
  int cyc = 0;
  int doneCount = 0;
  int lastDone = -1;
  int gaps[$];
  int busyRiseCount = 0;
  int busyRiseCyc = 0;
  int busyFallCyc = 0;
  logic prevBusy = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (doneFast) begin
      doneCount++;
      if (lastDone >= 0) gaps.push_back(cyc - lastDone);
      lastDone = cyc;
    end
    if (busyFast && !prevBusy) begin busyRiseCount++; busyRiseCyc = cyc; end
    if (!busyFast && prevBusy) busyFallCyc = cyc;
    prevBusy = busyFast;
  end

  task automatic applyStimulus(input logic [7:0] v, input logic [7:0] f,
                               input logic [3:0] d, input logic s);
    addrVal = v; addrFloat = f; dataIn = d; send = s;
  endtask

  task automatic waitPos(input int n);
    repeat (n * DIV_TB) @(negedge clk);
  endtask

  task automatic waitBusy(input logic level, input int limit, input string name);
    int n = 0;
    while (busyFast !== level && n < limit) begin @(negedge clk); n++; end
    checkOutput(name, int'(busyFast === level), 1);
  endtask

  // Samples one full frame, one sample per position, starting at position 0.
  task automatic captureFrame(output logic [511:0] f);
    for (int k = 0; k < FRAME; k++) begin
      f[511 - k] = codFast;
      waitPos(1);
    end
  endtask

  logic [511:0] capt;
  int base, n, sendCyc;

  initial begin
    reset = 1'b1; sendSlow = 1'b0;
    applyStimulus(8'h00, 8'h00, 4'h0, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: nothing happens without send.
    repeat (2000) @(negedge clk);
    checkOutput("idle_cod", int'(codFast), 0);
    checkOutput("idle_busy", int'(busyFast), 0);
    checkOutput("idle_done_count", doneCount, 0);
    checkOutput("idle_busy_rises", busyRiseCount, 0);

    // Short send: exactly MIN_FRAMES frames, address 0x01, data 0xA.
    base = doneCount;
    gaps.delete();
    applyStimulus(8'h01, 8'h00, 4'hA, 1'b1);
    waitBusy(1'b1, 4 * DIV_TB, "start_timeout");
    send = 1'b0;
    captureFrame(capt);
    checkOutput("bit0_shape", int'(capt[511 -: 32] == 32'hFFF0_FFF0), 1);
    checkOutput("bit1_shape", int'(capt[479 -: 32] == 32'hF000_F000), 1);
    checkOutput("d3_shape", int'(capt[255 -: 32] == 32'hFFF0_FFF0), 1);
    checkOutput("d2_shape", int'(capt[223 -: 32] == 32'hF000_F000), 1);
    checkOutput("d1_shape", int'(capt[191 -: 32] == 32'hFFF0_FFF0), 1);
    checkOutput("d0_shape", int'(capt[159 -: 32] == 32'hF000_F000), 1);
    checkOutput("sync_shape", int'(capt[127:0] == {4'hF, 124'd0}), 1);
    waitBusy(1'b0, 4 * FRAME * DIV_TB, "end_timeout");
    @(negedge clk);
    checkOutput("four_frames", doneCount - base, 4);
    checkOutput("gap_count", gaps.size(), 3);
    foreach (gaps[i]) checkOutput("done_spacing", gaps[i], FRAME * DIV_TB);
    checkOutput("busy_length", busyFallCyc - busyRiseCyc, 4 * FRAME * DIV_TB);

    // Floating A7 gives the F shape whatever addr_val[7] says.
    applyStimulus(8'h80, 8'h80, 4'hA, 1'b1);
    waitBusy(1'b1, 4 * DIV_TB, "float_start_timeout");
    send = 1'b0;
    captureFrame(capt);
    checkOutput("bit7_float", int'(capt[287 -: 32] == 32'hF000_FFF0), 1);
    checkOutput("bit6_zero", int'(capt[319 -: 32] == 32'hF000_F000), 1);
    waitBusy(1'b0, 4 * FRAME * DIV_TB, "float_end_timeout");

    // Held send; data changes mid-frame and shows up only in the next frame.
    base = doneCount;
    applyStimulus(8'h00, 8'h00, 4'hA, 1'b1);
    sendCyc = cyc;
    waitBusy(1'b1, 4 * DIV_TB, "hold_start_timeout");
    waitPos(100);
    dataIn = 4'h5;
    waitPos(8 * 32 + 4 - 100);
    checkOutput("frame1_d3", int'(codFast), 1);
    waitPos(FRAME);
    checkOutput("frame2_d3", int'(codFast), 0);
    waitPos(32);
    checkOutput("frame2_d2", int'(codFast), 1);
    while (cyc < sendCyc + 6 * FRAME * DIV_TB) @(negedge clk);
    send = 1'b0;
    waitBusy(1'b0, 3 * FRAME * DIV_TB, "hold_end_timeout");
    @(negedge clk);
    n = doneCount - base;
    checkOutput("six_or_seven_frames", int'(n == 6 || n == 7), 1);

    // Reset in the middle of frame 2 aborts immediately.
    applyStimulus(8'h3C, 8'h00, 4'h9, 1'b1);
    waitBusy(1'b1, 4 * DIV_TB, "abort_start_timeout");
    send = 1'b0;
    waitPos(FRAME + 200);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_cod", int'(codFast), 0);
    checkOutput("abort_busy", int'(busyFast), 0);
    checkOutput("abort_done", int'(doneFast), 0);
    reset = 1'b0;
    base = doneCount;
    n = busyRiseCount;
    repeat (3 * FRAME * DIV_TB) @(negedge clk);
    checkOutput("abort_quiet_done", doneCount - base, 0);
    checkOutput("abort_quiet_busy", busyRiseCount - n, 0);
    checkOutput("abort_quiet_state", int'(busyFast), 0);

    // Default divider: first high pulse of a '0' symbol lasts 4 ticks of 250 clks.
    applyStimulus(8'h00, 8'h00, 4'h0, 1'b0);
    sendSlow = 1'b1;
    n = 0;
    while (!codSlow && n < 300) begin @(negedge clk); n++; end
    sendSlow = 1'b0;
    checkOutput("slow_start", int'(codSlow), 1);
    checkOutput("slow_busy", int'(busySlow), 1);
    n = 0;
    while (codSlow && n < 2000) begin n++; @(negedge clk); end
    checkOutput("slow_first_pulse", n, 1000);
    checkOutput("slow_no_done", int'(doneSlow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
